// File: rtl/uart_header_link_pkg.sv
// Shared constants and state encodings for the UART header/result link.
package uart_header_link_pkg;

    localparam int UART_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_LOAD = 1'b1
    } frame_state_t;

endpackage

// File: rtl/uart_header_link_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, start-glitch rejection, mid-bit sampling.
module uart_rx_byte
    import uart_header_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [UART_BITS-1:0] byte_data,
    output logic                 byte_strobe,
    output logic                 frame_err
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // sync_r[1] is the synchronised line, sync_r[2] its previous value for edge detection
    logic [2:0]           sync_r;
    rx_state_t            state_r;
    logic [CW-1:0]        cnt_r;
    logic [2:0]           bit_idx_r;
    logic [UART_BITS-1:0] shift_r;
    logic [UART_BITS-1:0] byte_data_r;
    logic                 strobe_r;
    logic                 ferr_r;

    // Synchroniser and receive byte state machine
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r      <= 3'b111;
            state_r     <= RX_IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= '0;
            byte_data_r <= '0;
            strobe_r    <= 1'b0;
            ferr_r      <= 1'b0;
        end else begin
            sync_r   <= {sync_r[1:0], rxd};
            strobe_r <= 1'b0;
            ferr_r   <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (sync_r[2] && !sync_r[1]) begin
                        state_r <= RX_START;
                    end else begin
                        state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r   <= '0;
                        state_r <= sync_r[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r     <= '0;
                        shift_r   <= {sync_r[1], shift_r[UART_BITS-1:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            state_r <= RX_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= RX_IDLE;
                        if (sync_r[1]) begin
                            byte_data_r <= shift_r;
                            strobe_r    <= 1'b1;
                        end else begin
                            ferr_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign byte_data   = byte_data_r;
    assign byte_strobe = strobe_r;
    assign frame_err   = ferr_r;

endmodule

// File: rtl/uart_header_link.sv
// Miner serial link: assembles UART bytes into a shadowed header word with
// inter-byte timeout, and transmits a result word under valid/ready.
module uart_header_link
    import uart_header_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HEADER_BYTES = 80,
    parameter int RESULT_BYTES = 4,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              rxd,
    output logic                              txd,
    output logic [HEADER_BYTES*8-1:0]         header_data,
    output logic                              header_valid,
    input  logic [RESULT_BYTES*8-1:0]         result_data,
    input  logic                              result_valid,
    output logic                              result_ready,
    output logic                              frame_err,
    output logic                              timeout_err,
    output logic [$clog2(HEADER_BYTES+1)-1:0] byte_count
);

    localparam int HW  = HEADER_BYTES * 8;
    localparam int RW  = RESULT_BYTES * 8;
    localparam int BCW = $clog2(HEADER_BYTES + 1);
    localparam int TCW = $clog2(TIMEOUT_CLKS + 1);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int RBW = $clog2(RESULT_BYTES + 1);

    localparam logic [BCW-1:0] LAST_BYTE    = BCW'(HEADER_BYTES - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0]  BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [RBW-1:0] LAST_RESULT  = RBW'(RESULT_BYTES - 1);

    logic [UART_BITS-1:0] byte_data_s;
    logic                 byte_strobe_s;
    logic                 frame_err_s;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rxd         (rxd),
        .byte_data   (byte_data_s),
        .byte_strobe (byte_strobe_s),
        .frame_err   (frame_err_s)
    );

    frame_state_t   fstate_r;
    logic [HW-1:0]  shadow_r;
    logic [HW-1:0]  header_data_r;
    logic           header_valid_r;
    logic           timeout_err_r;
    logic [BCW-1:0] byte_count_r;
    logic [TCW-1:0] idle_cnt_r;

    // Frame assembly and inter-byte timeout; a byte strobe always beats the timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fstate_r       <= F_IDLE;
            shadow_r       <= '0;
            header_data_r  <= '0;
            header_valid_r <= 1'b0;
            timeout_err_r  <= 1'b0;
            byte_count_r   <= '0;
            idle_cnt_r     <= '0;
        end else begin
            header_valid_r <= 1'b0;
            timeout_err_r  <= 1'b0;
            if (byte_strobe_s) begin
                idle_cnt_r <= '0;
                if (byte_count_r == LAST_BYTE) begin
                    header_data_r  <= {shadow_r[HW-9:0], byte_data_s};
                    header_valid_r <= 1'b1;
                    shadow_r       <= '0;
                    byte_count_r   <= '0;
                    fstate_r       <= F_IDLE;
                end else begin
                    shadow_r     <= {shadow_r[HW-9:0], byte_data_s};
                    byte_count_r <= byte_count_r + BCW'(1);
                    fstate_r     <= F_LOAD;
                end
            end else if (fstate_r == F_LOAD) begin
                if (idle_cnt_r == TIMEOUT_LAST) begin
                    shadow_r      <= '0;
                    byte_count_r  <= '0;
                    timeout_err_r <= 1'b1;
                    idle_cnt_r    <= '0;
                    fstate_r      <= F_IDLE;
                end else begin
                    idle_cnt_r <= idle_cnt_r + TCW'(1);
                end
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end

    tx_state_t            tx_state_r;
    logic                 txd_r;
    logic                 ready_r;
    logic [RW-1:0]        tx_word_r;
    logic [UART_BITS-1:0] tx_byte_r;
    logic [CW-1:0]        tx_cnt_r;
    logic [2:0]           tx_bit_r;
    logic [RBW-1:0]       tx_byte_idx_r;

    // Transmitter: captured word leaves MSB byte first, bytes back to back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_r    <= TX_IDLE;
            txd_r         <= 1'b1;
            ready_r       <= 1'b1;
            tx_word_r     <= '0;
            tx_byte_r     <= '0;
            tx_cnt_r      <= '0;
            tx_bit_r      <= 3'd0;
            tx_byte_idx_r <= '0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r      <= '0;
                    tx_bit_r      <= 3'd0;
                    tx_byte_idx_r <= '0;
                    if (result_valid && ready_r) begin
                        tx_byte_r  <= result_data[RW-1 -: 8];
                        tx_word_r  <= result_data << 4'd8;
                        ready_r    <= 1'b0;
                        txd_r      <= 1'b0;
                        tx_state_r <= TX_START;
                    end else begin
                        ready_r <= 1'b1;
                        txd_r   <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx_bit_r   <= 3'd0;
                        txd_r      <= tx_byte_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_bit_r == 3'd7) begin
                            txd_r      <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_bit_r <= tx_bit_r + 3'd1;
                            txd_r    <= tx_byte_r[tx_bit_r + 3'd1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_byte_idx_r == LAST_RESULT) begin
                            ready_r    <= 1'b1;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_byte_idx_r <= tx_byte_idx_r + RBW'(1);
                            tx_byte_r     <= tx_word_r[RW-1 -: 8];
                            tx_word_r     <= tx_word_r << 4'd8;
                            txd_r         <= 1'b0;
                            tx_state_r    <= TX_START;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    txd_r      <= 1'b1;
                    ready_r    <= 1'b1;
                end
            endcase
        end
    end

    assign txd          = txd_r;
    assign result_ready = ready_r;
    assign header_data  = header_data_r;
    assign header_valid = header_valid_r;
    assign frame_err    = frame_err_s;
    assign timeout_err  = timeout_err_r;
    assign byte_count   = byte_count_r;

endmodule

// File: tb/tb_uart_header_link.sv
// Directed bench for uart_header_link with small bit period, 4-byte header and result.
module tb_uart_header_link;

    localparam int CPB = 8;
    localparam int HB  = 4;
    localparam int RB  = 4;
    localparam int TO  = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rxd   = 1'b1;
    logic        txd;
    logic [31:0] header_data;
    logic        header_valid;
    logic [31:0] result_data  = 32'h0;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic        frame_err;
    logic        timeout_err;
    logic [2:0]  byte_count;

    int errors = 0;
    int checks = 0;
    int hv_cnt = 0;
    int fe_cnt = 0;
    int to_cnt = 0;
    int rdy_low_cnt = 0;

    logic [31:0] got_a;
    logic [31:0] got_b;
    int bad_a, bad_b, h0, f0, t0, r0;

    uart_header_link #(
        .CLKS_PER_BIT (CPB),
        .HEADER_BYTES (HB),
        .RESULT_BYTES (RB),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rxd          (rxd),
        .txd          (txd),
        .header_data  (header_data),
        .header_valid (header_valid),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err),
        .byte_count   (byte_count)
    );

    always #5 clock = ~clock;

    // Pulse and ready-low counters, sampled away from the active edge
    always @(negedge clock) begin
        if (header_valid) hv_cnt <= hv_cnt + 1;
        if (frame_err)    fe_cnt <= fe_cnt + 1;
        if (timeout_err)  to_cnt <= to_cnt + 1;
        if (!result_ready) rdy_low_cnt <= rdy_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clock);
        end
        rxd = stop;
        repeat (CPB) @(negedge clock);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send_byte(w[31 - 8*j -: 8], 1'b1);
        repeat (4) @(negedge clock);
    endtask

    // Pulses result_valid for one cycle, then decodes 40 bit periods of txd at mid-bit
    task automatic tx_send_collect(input logic [31:0] w, output logic [31:0] got, output int bad);
        bad = 0;
        got = 32'h0;
        result_data  = w;
        result_valid = 1'b1;
        @(negedge clock);
        result_valid = 1'b0;
        repeat (CPB/2) @(negedge clock);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 10; k++) begin
                if (k == 0) begin
                    if (txd !== 1'b0) bad++;
                end else if (k == 9) begin
                    if (txd !== 1'b1) bad++;
                end else begin
                    got[(3-j)*8 + k - 1] = txd;
                end
                repeat (CPB) @(negedge clock);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_txd", txd, 1);
        check("rst_header", header_data, 0);
        check("rst_hvalid", header_valid, 0);
        check("rst_ready", result_ready, 1);
        check("rst_ferr", frame_err, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_bcount", byte_count, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // Basic header
        h0 = hv_cnt;
        send_frame(32'hDEADBEEF);
        check("hdr1_data", header_data, 32'hDEADBEEF);
        check("hdr1_pulses", hv_cnt - h0, 1);
        check("hdr1_bcount", byte_count, 0);

        // Timeout discards a partial frame
        h0 = hv_cnt; t0 = to_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (2) @(negedge clock);
        check("to_partial_bcount", byte_count, 2);
        repeat (250) @(negedge clock);
        check("to_pulses", to_cnt - t0, 1);
        check("to_bcount", byte_count, 0);
        check("to_header_kept", header_data, 32'hDEADBEEF);
        check("to_no_hvalid", hv_cnt - h0, 0);
        send_frame(32'hAABBCCDD);
        check("to_next_header", header_data, 32'hAABBCCDD);

        // Framing error drops one byte only
        f0 = fe_cnt; h0 = hv_cnt;
        send_byte(8'h55, 1'b0);
        repeat (16) @(negedge clock);
        check("fe_pulses", fe_cnt - f0, 1);
        check("fe_bcount", byte_count, 0);
        send_frame(32'h01020304);
        check("fe_header", header_data, 32'h01020304);
        check("fe_hvalid", hv_cnt - h0, 1);

        // Transmit with a second request ignored mid-transfer
        r0 = rdy_low_cnt;
        fork
            tx_send_collect(32'h12345678, got_a, bad_a);
            begin
                repeat (100) @(negedge clock);
                result_data  = 32'hFFFFFFFF;
                result_valid = 1'b1;
                @(negedge clock);
                result_valid = 1'b0;
            end
        join
        repeat (20) @(negedge clock);
        check("tx_word", got_a, 32'h12345678);
        check("tx_framing", bad_a, 0);
        check("tx_ready_low", rdy_low_cnt - r0, 320);
        check("tx_idle_txd", txd, 1);
        check("tx_idle_ready", result_ready, 1);

        // Glitch on rxd is not a byte
        f0 = fe_cnt; h0 = hv_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clock);
        rxd = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_bcount", byte_count, 0);
        check("glitch_ferr", fe_cnt - f0, 0);

        // Full duplex
        fork
            send_frame(32'hCAFEBABE);
            tx_send_collect(32'hA5C30F96, got_b, bad_b);
        join
        repeat (10) @(negedge clock);
        check("fd_header", header_data, 32'hCAFEBABE);
        check("fd_hvalid", hv_cnt - h0, 1);
        check("fd_tx_word", got_b, 32'hA5C30F96);
        check("fd_tx_framing", bad_b, 0);

        // Reset mid-frame and mid-transmit
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        repeat (2) @(negedge clock);
        check("mr_bcount_pre", byte_count, 2);
        result_data  = 32'h00000000;
        result_valid = 1'b1;
        @(negedge clock);
        result_valid = 1'b0;
        repeat (20) @(negedge clock);
        check("mr_txd_busy", txd, 0);
        reset = 1'b0;
        #1;
        check("mr_txd", txd, 1);
        check("mr_ready", result_ready, 1);
        check("mr_header", header_data, 0);
        check("mr_bcount", byte_count, 0);
        check("mr_hvalid", header_valid, 0);
        check("mr_terr", timeout_err, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        h0 = hv_cnt;
        send_frame(32'h0A0B0C0D);
        check("mr_next_header", header_data, 32'h0A0B0C0D);
        check("mr_next_hvalid", hv_cnt - h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
